serial_add_controller: RTL

- Parallel-to-serial front end and serial-to-parallel back end for bit-serial addition.
- Accepts two N-bit operands in parallel and streams them LSB-first through an internal one-bit full-adder stage with a registered carry, one bit per clock.
- Reassembles the sum bits into a parallel N-bit result and reports carry-out with a start/busy/done handshake.
- Supports add and subtract (two's complement) modes; sits between a parallel register file and a bit-serial datapath.

---
 rtl/serial_add_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_add_controller.sv
// Bit-serial adder/subtractor controller: loads two parallel operands, streams them LSB-first
// through a one-bit full adder with registered carry, and reassembles the parallel result.
module serial_add_controller #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sha_q, sha_d;
    logic [N-1:0]  shb_q, shb_d;
    logic [N-1:0]  shs_q, shs_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          sbit_s;
    logic          cnext_s;
    logic          last_bit_s;

    assign sbit_s     = sha_q[0] ^ shb_q[0] ^ carry_q;
    assign cnext_s    = ((sha_q[0] ^ shb_q[0]) & carry_q) | (sha_q[0] & shb_q[0]);
    assign last_bit_s = (cnt_q == CW'(N - 1));

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sha_q   <= {N{1'b0}};
            shb_q   <= {N{1'b0}};
            shs_q   <= {N{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            sum_q   <= {N{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shs_q   <= shs_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; subtract loads ~B with carry 1 so the adder forms A - B
    always_comb begin
        sha_d   = sha_q;
        shb_d   = shb_q;
        shs_d   = shs_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sha_d   = a_in;
                    shb_d   = mode ? ~b_in : b_in;
                    carry_d = mode ? 1'b1 : c_in;
                    shs_d   = {N{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                sha_d   = {1'b0, sha_q[N-1:1]};
                shb_d   = {1'b0, shb_q[N-1:1]};
                shs_d   = {sbit_s, shs_q[N-1:1]};
                carry_d = cnext_s;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit_s) begin
                    sum_d  = {sbit_s, shs_q[N-1:1]};
                    cout_d = cnext_s;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign sum   = sum_q;
    assign c_out = cout_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
